// File: rtl/imm_alu_sequencer.sv
// rtl/imm_alu_sequencer.sv - T-state control sequencer for ANDI/ORI/ADDI immediate instructions
module imm_alu_sequencer #(
    parameter int                    OPC_W       = 5,
    parameter int                    ALU_OP_W    = 4,
    parameter int                    STEP_CYCLES = 1,
    parameter logic [OPC_W-1:0]      OPC_ANDI    = 5'b01100,
    parameter logic [OPC_W-1:0]      OPC_ORI     = 5'b01101,
    parameter logic [OPC_W-1:0]      OPC_ADDI    = 5'b01011,
    parameter logic [ALU_OP_W-1:0]   ALU_AND     = 4'b0101,
    parameter logic [ALU_OP_W-1:0]   ALU_OR      = 4'b0110,
    parameter logic [ALU_OP_W-1:0]   ALU_ADD     = 4'b0011
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Read,
    output logic                MD_read,
    output logic                MDRout,
    output logic                Grb,
    output logic                Rout,
    output logic                Csignout,
    output logic                Gra,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zlowin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Rin,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_T6   = 3'd7;

    localparam logic [3:0] LAST_CNT = 4'(STEP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_cyc;
    logic [OPC_W-1:0] opc;
    logic             opc_ok;
    logic             unused_ir_bits;

    assign opc            = ir[31:32-OPC_W];
    assign unused_ir_bits = ^ir[31-OPC_W:0];
    assign last_cyc       = (cnt_q == LAST_CNT);
    assign opc_ok         = (opc == OPC_ANDI) || (opc == OPC_ORI) || (opc == OPC_ADDI);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   if (last_cyc) state_d = S_T1;
            // T1 waits for memory; the counter saturates at its last value meanwhile
            S_T1:   if (last_cyc && mem_ready) state_d = S_T2;
            S_T2:   if (last_cyc) state_d = S_T3;
            S_T3:   if (last_cyc) state_d = S_T4;
            S_T4: begin
                if (!opc_ok)       state_d = S_IDLE;
                else if (last_cyc) state_d = S_T5;
            end
            S_T5:   if (last_cyc) state_d = S_T6;
            S_T6:   if (last_cyc) state_d = run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE || state_d != state_q) begin
            cnt_d = 4'd0;
        end else if (!last_cyc) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Read     = 1'b0;
        MD_read  = 1'b0;
        MDRout   = 1'b0;
        Grb      = 1'b0;
        Rout     = 1'b0;
        Csignout = 1'b0;
        Gra      = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zlowin   = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Rin      = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = last_cyc;
                IncPC  = last_cyc;
                Zlowin = last_cyc;
            end
            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                PCin    = last_cyc && mem_ready;
            end
            S_T2: begin
                MD_read = 1'b1;
                MDRin   = last_cyc;
            end
            S_T3: begin
                MDRout = 1'b1;
                IRin   = last_cyc;
            end
            // ir first becomes trustworthy here; a bad opcode aborts the instruction
            S_T4: begin
                if (opc_ok) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = last_cyc;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_T5: begin
                Csignout = 1'b1;
                Zlowin   = last_cyc;
                if (opc == OPC_ANDI)      alu_op = ALU_AND;
                else if (opc == OPC_ORI)  alu_op = ALU_OR;
                else if (opc == OPC_ADDI) alu_op = ALU_ADD;
            end
            S_T6: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = last_cyc;
                done    = last_cyc;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule
